m_trig_seq: RTL
===============

M_TRIG_SEQ -- requirements
Module: m_trig_seq

Interface
REQ-001 Parameter WIDTH, default 640: samples written per captured frame.
REQ-002 Parameter BUS, default 11: width of the write-address counter.
REQ-003 Parameter TIMEOUT, default 24'd1000000: auto-mode trigger wait limit, in CLK_ADC cycles.
REQ-004 CLK_ADC  in  1  sole clock; all logic is on its rising edge.
REQ-005 RST_N  in  1  reset, asynchronous assert, active-low.
REQ-006 D  in  8  ADC sample, valid every cycle.
REQ-007 LEVEL  in  8  trigger threshold, unsigned.
REQ-008 SLOPE  in  1  1 = rising-edge trigger, 0 = falling-edge trigger.
REQ-009 MODE  in  2  00 auto, 01 normal, 10 single, 11 stop.
REQ-010 ARM  in  1  single-cycle pulse that arms single mode.
REQ-011 HOLDOFF  in  16  cycles to wait after a bank swap before arming.
REQ-012 SWAP_REQ  in  1  single-cycle display frame-boundary pulse, already in the CLK_ADC domain.
REQ-013 WR_ADDR  out  BUS  buffer write address.
REQ-014 WR_EN  out  1  buffer write enable.
REQ-015 BANK  out  1  buffer write bank; the display reads ~BANK.
REQ-016 FRAME_READY  out  1  one-cycle pulse when a capture completes.
REQ-017 TRIGGERED  out  1  1 while capturing a frame that was started by a real trigger.
REQ-018 TIMEOUT_FLAG  out  1  1 while capturing, and until the next capture starts, if the frame was forced by timeout.
REQ-019 STATE  out  3  current state encoding: IDLE 0, HOLD 1, ARMED 2, CAPT 3, DONE 4.

Function
REQ-020 All outputs SHALL be registered.
REQ-021 IDLE SHALL behave as follows:
- MODE 00 or 01: go to HOLD on the next cycle.
- MODE 10: go to HOLD on the cycle after ARM=1; stay in IDLE without ARM.
- MODE 11: stay in IDLE.
REQ-022 HOLD SHALL count HOLDOFF cycles, then enter ARMED; HOLDOFF=0 enters ARMED on the next cycle.
REQ-023 On ARMED entry, the prev-sample register SHALL be invalidated, and the 24-bit timeout counter SHALL be cleared.
REQ-024 Trigger detection SHALL be evaluated only in ARMED and only with prev valid:
- rising = prev < LEVEL and D >= LEVEL;
- falling = prev > LEVEL and D <= LEVEL.
REQ-025 When a trigger is detected, the block SHALL enter CAPT on the next cycle, with TRIGGERED=1 and TIMEOUT_FLAG=0.
REQ-026 In MODE 00, when the timeout count reaches TIMEOUT-1 with no trigger, the block SHALL enter CAPT with TRIGGERED=0 and TIMEOUT_FLAG=1.
REQ-027 In MODE 01 and 10, ARMED SHALL wait indefinitely.
REQ-028 MODE=11 observed in ARMED or HOLD SHALL return the block to IDLE on the next cycle, with no write and no FRAME_READY.
REQ-029 CAPT SHALL assert WR_EN for exactly WIDTH consecutive cycles, with WR_ADDR = 0,1,...,WIDTH-1.
- The first write stores the sample that follows the trigger cycle.
- MODE changes SHALL NOT abort CAPT.
REQ-030 After the write at WIDTH-1, the block SHALL enter DONE:
- WR_EN=0 and WR_ADDR=0;
- FRAME_READY=1 for exactly the DONE entry cycle;
- TRIGGERED is cleared.
REQ-031 SWAP_REQ SHALL be sampled only in DONE, including the DONE entry cycle; SWAP_REQ in any other state SHALL be ignored.
REQ-032 On SWAP_REQ=1 in DONE, BANK SHALL toggle on the next edge, and the next state SHALL be:
- HOLD for MODE 00 or 01;
- IDLE for MODE 10 or 11.
REQ-033 ARM SHALL be ignored outside IDLE.
REQ-034 BANK SHALL change only per REQ-032, so the bank being written never toggles during CAPT.
REQ-035 Counter arithmetic:
- the holdoff counter is 16 bits;
- the timeout counter is 24 bits and saturates;
- the address counter is BUS bits and never wraps, because CAPT ends at WIDTH-1.

Reset
REQ-036 While RST_N=0, outputs SHALL be: STATE=IDLE, WR_ADDR=0, WR_EN=0, BANK=0, FRAME_READY=0, TRIGGERED=0, TIMEOUT_FLAG=0; all counters and prev-valid SHALL also be 0.
REQ-037 Reset asserted mid-CAPT SHALL force WR_EN=0 asynchronously, with no FRAME_READY and no BANK toggle.
REQ-038 After reset release, the first active edge SHALL evaluate IDLE rules.

Verification
REQ-039 Auto mode, rising trigger: WIDTH=8, MODE=00, SLOPE=1, LEVEL=0x80, HOLDOFF=2, ramp D 0x70,0x7F,0x80,... -> trigger on the 0x7F->0x80 step; WR_EN high 8 cycles, addr 0..7; FRAME_READY pulse; TRIGGERED=1 during CAPT.
REQ-040 Auto mode, timeout: MODE=00, TIMEOUT=16, D constant 0x10 -> CAPT entered 16 cycles after ARMED entry; TIMEOUT_FLAG=1, TRIGGERED=0.
REQ-041 Normal mode, falling trigger: MODE=01, SLOPE=0, LEVEL=0x40, D constant 0x30 for 10000 cycles -> stays ARMED; then D 0x50->0x40 -> capture starts.
REQ-042 Single mode and bank handshake: MODE=10, ARM pulse -> one frame captured; SWAP_REQ in DONE -> BANK 0->1, STATE=IDLE; a second ARM -> another frame, BANK 1->0 on the next swap; SWAP_REQ sent during CAPT -> BANK unchanged.
REQ-043 Stop and reset: MODE=11 while ARMED -> IDLE, no writes; RST_N low at WR_ADDR=5 of CAPT -> WR_EN=0 immediately, all outputs at reset values, no FRAME_READY.

Source files
------------

// File: rtl/m_trig_seq_if.sv
// Signal bundle between the trigger sequencer, the ADC front end and the
// double-banked capture buffer.
interface m_trig_seq_if #(
    parameter int BUS = 11
);
    logic [7:0]     D;
    logic [7:0]     LEVEL;
    logic           SLOPE;
    logic [1:0]     MODE;
    logic           ARM;
    logic [15:0]    HOLDOFF;
    logic           SWAP_REQ;
    logic [BUS-1:0] WR_ADDR;
    logic           WR_EN;
    logic           BANK;
    logic           FRAME_READY;
    logic           TRIGGERED;
    logic           TIMEOUT_FLAG;
    logic [2:0]     STATE;

    modport master (
        output D, LEVEL, SLOPE, MODE, ARM, HOLDOFF, SWAP_REQ,
        input  WR_ADDR, WR_EN, BANK, FRAME_READY, TRIGGERED, TIMEOUT_FLAG, STATE
    );

    modport slave (
        input  D, LEVEL, SLOPE, MODE, ARM, HOLDOFF, SWAP_REQ,
        output WR_ADDR, WR_EN, BANK, FRAME_READY, TRIGGERED, TIMEOUT_FLAG, STATE
    );
endinterface

// File: rtl/m_trig_seq.sv
// Oscilloscope trigger sequencer: holdoff, edge/timeout trigger, one frame
// capture into the write bank, then a bank swap on the display frame boundary.
module m_trig_seq #(
    parameter int          WIDTH   = 640,
    parameter int          BUS     = 11,
    parameter logic [23:0] TIMEOUT = 24'd1000000
) (
    input  logic        CLK_ADC,
    input  logic        RST_N,
    m_trig_seq_if.slave ctl
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HOLD  = 3'd1,
        S_ARMED = 3'd2,
        S_CAPT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_AUTO   = 2'b00;
    localparam logic [1:0] MODE_NORM   = 2'b01;
    localparam logic [1:0] MODE_SINGLE = 2'b10;
    localparam logic [1:0] MODE_STOP   = 2'b11;

    localparam logic [BUS-1:0] LAST_ADDR = BUS'(WIDTH - 1);
    localparam logic [23:0]    TMO_LAST  = TIMEOUT - 24'd1;

    state_t         state, state_nxt;
    logic [15:0]    hold_cnt, hold_cnt_nxt;
    logic [23:0]    to_cnt, to_cnt_nxt;
    logic [7:0]     prev, prev_nxt;
    logic           prev_vld, prev_vld_nxt;
    logic [BUS-1:0] wr_addr, wr_addr_nxt;
    logic           wr_en, wr_en_nxt;
    logic           bank, bank_nxt;
    logic           frame_ready, frame_ready_nxt;
    logic           triggered, triggered_nxt;
    logic           timeout_flag, timeout_flag_nxt;
    logic           trig_hit, tmo_hit, trig_go, tmo_go;

    function automatic logic [23:0] sat_inc24(input logic [23:0] v);
        return (v == 24'hFF_FFFF) ? v : v + 24'd1;
    endfunction

    function automatic logic crossing(input logic [7:0] p, input logic [7:0] cur,
                                      input logic [7:0] lvl, input logic rise);
        return rise ? ((p < lvl) && (cur >= lvl)) : ((p > lvl) && (cur <= lvl));
    endfunction

    // A sample pair straddling ARMED entry never counts: prev_vld is only set from inside ARMED.
    assign trig_hit = (state == S_ARMED) && prev_vld && crossing(prev, ctl.D, ctl.LEVEL, ctl.SLOPE);
    assign tmo_hit  = (state == S_ARMED) && (ctl.MODE == MODE_AUTO) && (to_cnt >= TMO_LAST);

    always_ff @(posedge CLK_ADC or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (ctl.MODE == MODE_AUTO || ctl.MODE == MODE_NORM)  state_nxt = S_HOLD;
                else if (ctl.MODE == MODE_SINGLE && ctl.ARM)         state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (ctl.MODE == MODE_STOP)          state_nxt = S_IDLE;
                else if (hold_cnt == ctl.HOLDOFF)   state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (ctl.MODE == MODE_STOP)          state_nxt = S_IDLE;
                else if (trig_hit || tmo_hit)       state_nxt = S_CAPT;
            end
            S_CAPT: begin
                if (wr_addr == LAST_ADDR)           state_nxt = S_DONE;
            end
            S_DONE: begin
                if (ctl.SWAP_REQ)
                    state_nxt = (ctl.MODE == MODE_SINGLE || ctl.MODE == MODE_STOP) ? S_IDLE : S_HOLD;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values for every registered output and counter.
    always_comb begin
        trig_go          = (state == S_ARMED) && (state_nxt == S_CAPT) && trig_hit;
        tmo_go           = (state == S_ARMED) && (state_nxt == S_CAPT) && !trig_hit;
        hold_cnt_nxt     = (state == S_HOLD && state_nxt == S_HOLD) ? hold_cnt + 16'd1 : 16'd0;
        to_cnt_nxt       = (state == S_ARMED && state_nxt == S_ARMED) ? sat_inc24(to_cnt) : 24'd0;
        prev_vld_nxt     = (state == S_ARMED) && (state_nxt == S_ARMED);
        prev_nxt         = (state == S_ARMED) ? ctl.D : prev;
        wr_en_nxt        = (state_nxt == S_CAPT);
        wr_addr_nxt      = (state == S_CAPT && state_nxt == S_CAPT) ? wr_addr + BUS'(1) : '0;
        frame_ready_nxt  = (state == S_CAPT) && (state_nxt == S_DONE);
        bank_nxt         = (state == S_DONE && ctl.SWAP_REQ) ? ~bank : bank;
        triggered_nxt    = trig_go ? 1'b1 : (frame_ready_nxt ? 1'b0 : triggered);
        timeout_flag_nxt = tmo_go ? 1'b1 : (trig_go ? 1'b0 : timeout_flag);
    end

    always_ff @(posedge CLK_ADC or negedge RST_N) begin
        if (!RST_N) begin
            hold_cnt     <= '0;
            to_cnt       <= '0;
            prev_vld     <= 1'b0;
            wr_addr      <= '0;
            wr_en        <= 1'b0;
            bank         <= 1'b0;
            frame_ready  <= 1'b0;
            triggered    <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            hold_cnt     <= hold_cnt_nxt;
            to_cnt       <= to_cnt_nxt;
            prev_vld     <= prev_vld_nxt;
            wr_addr      <= wr_addr_nxt;
            wr_en        <= wr_en_nxt;
            bank         <= bank_nxt;
            frame_ready  <= frame_ready_nxt;
            triggered    <= triggered_nxt;
            timeout_flag <= timeout_flag_nxt;
        end
    end

    // Sample history is data only; its validity is tracked by prev_vld.
    always_ff @(posedge CLK_ADC) begin
        prev <= prev_nxt;
    end

    assign ctl.STATE        = state;
    assign ctl.WR_ADDR      = wr_addr;
    assign ctl.WR_EN        = wr_en;
    assign ctl.BANK         = bank;
    assign ctl.FRAME_READY  = frame_ready;
    assign ctl.TRIGGERED    = triggered;
    assign ctl.TIMEOUT_FLAG = timeout_flag;
endmodule
